mhpm_overflow_collector: RTL
============================

// Module: mhpm_overflow_collector
// PURPOSE
//  Upstream feeder of the difftest MhpmeventOverflow event. Tracks the sticky Sscofpmf OF bit of each
//  mhpmevent3..31 and detects new counter overflows. Coalesces them into a 64-bit overflow vector
//  (bit n = mhpmevent n) and issues one-cycle event beats to the difftest sink, with ready-based hold-off.
//  Also raises the LCOFI set pulse toward the interrupt logic. Sits between the HPM counter bank and the difftest sink.
// PARAMETERS
//  NUM_HPM    29  number of programmable counters (mhpmevent3..31)
//  CNT_BASE   3   CSR index of the first programmable counter
//  OVF_W      64  width of the reported overflow vector
//  COREID_W   8   core id width
//  CNT_W      16  width of the coalesce statistics counter
// PORTS
//  clock                     in   1         core clock
//  reset                     in   1         asynchronous, active-low reset
//  io_hartId                 in   COREID_W  core id, passed through to the event
//  io_ovf_pulse              in   NUM_HPM   bit i: counter CNT_BASE+i wrapped this cycle
//  io_of_wen                 in   1         CSR write of an OF bit
//  io_of_widx                in   5         mhpmevent index of the write
//  io_of_wdata               in   1         OF value written
//  io_of_bits                out  NUM_HPM   current sticky OF bits
//  io_lcofi_set              out  1         one-cycle pulse: at least one OF went 0->1
//  io_diff_ready             in   1         difftest sink accepts an event this cycle
//  io_diff_enable            out  1         event strobe to sink (== io_diff_valid)
//  io_diff_valid             out  1         event beat valid
//  io_diff_mhpmeventOverflow out  OVF_W     overflow vector of this beat
//  io_diff_coreid            out  COREID_W  registered copy of io_hartId
//  io_coalesce_cnt           out  CNT_W     saturating count of merges while held off
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - of, pend, all outputs, and coalesce_cnt = 0.
//  - A reset mid-operation discards pending bits; no beat is emitted for them.
//  OF update, per cycle:
//  - new_set[i] = io_ovf_pulse[i] & ~of[i].
//  - of[i] <= 1 on io_ovf_pulse[i].
//  - Otherwise, a CSR write with io_of_widx == CNT_BASE+i sets of[i] <= io_of_wdata.
//  - Hardware set beats a same-cycle CSR clear.
//  - A CSR write of 1 never creates new_set, a report, or LCOFI.
//  - io_of_widx < CNT_BASE is ignored.
//  - An overflow while of[i] is already 1 is dropped: no report, no LCOFI.
//  LCOFI:
//  - io_lcofi_set is registered: high in cycle N+1 iff |new_set in cycle N.
//  Reporting:
//  - nv = new_set mapped to bits CNT_BASE..CNT_BASE+NUM_HPM-1.
//  - Bits 0..2 and 32..63 of every beat are 0.
//  - If io_diff_ready and (pend|nv) != 0 in cycle N:
//    - cycle N+1: valid = enable = 1, vector = pend|nv, coreid = io_hartId sampled at N.
//    - pend <= 0.
//  - Else if (pend|nv) != 0: pend <= pend|nv; valid = 0 in N+1.
//  - Else: valid = 0 in N+1.
//  - valid is a single-cycle pulse per beat; back-to-back beats are allowed.
//  - Latency: overflow at cycle N with ready=1 -> beat at N+1.
//  - No bit is lost or duplicated; the same bit arriving twice while held off is reported once.
//  Statistics:
//  - coalesce_cnt += 1 when !ready, nv != 0 and pend != 0.
//  - It saturates at 2^CNT_W-1 and never wraps.
// STRUCTURE
//  - Package mhpm_ovf_pkg: NUM_HPM, CNT_BASE, OVF_W, CNT_W.
//    - Also holds function hpm_to_vec(logic [NUM_HPM-1:0]) -> logic [OVF_W-1:0].
//  - Top holds the OF register file and LCOFI logic.
//  - Sub-module mhpm_ovf_coalescer holds pend, the output beat register and coalesce_cnt.
// TESTING
//  1. Reset low mid-hold with pend=0x8 -> all outputs 0; no beat after release.
//  2. ready=1, ovf_pulse bit0 at cycle 5:
//     -> cycle 6: valid=1, vector=0x0000_0000_0000_0008, lcofi_set=1, of_bits[0]=1.
//  3. ready=0 cycles 10-14; ovf bit0 @10, bit28 @12, bit0 cleared by CSR then re-overflow @13; ready=1 @15:
//     -> single beat @16, vector=0x0000_0000_8000_0008, coalesce_cnt=2.
//  4. of[5]=1; ovf_pulse bit5 -> no beat, no lcofi_set.
//     CSR write widx=8 wdata=0 with same-cycle ovf bit5 -> of[5] stays 1.
//  5. CSR write widx=2 wdata=1 -> of_bits unchanged.
//     CSR write widx=31 wdata=1 -> of_bits[28]=1, no beat, no lcofi_set.
//  6. ready=0 with pend!=0 and an overflow every cycle for 70000 cycles -> coalesce_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/mhpm_ovf_pkg.sv
// mhpm_ovf_pkg: shared sizes and the counter-to-overflow-vector mapping
package mhpm_ovf_pkg;
  localparam int NUM_HPM  = 29;
  localparam int CNT_BASE = 3;
  localparam int OVF_W    = 64;
  localparam int COREID_W = 8;
  localparam int CNT_W    = 16;
  function automatic logic [OVF_W-1:0] hpm_to_vec(input logic [NUM_HPM-1:0] v);
    hpm_to_vec = OVF_W'(v) << CNT_BASE;
  endfunction
endpackage

// File: rtl/mhpm_ovf_coalescer.sv
// mhpm_ovf_coalescer: merges overflow vectors while the sink holds off and emits one-cycle beats
module mhpm_ovf_coalescer
  import mhpm_ovf_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [OVF_W-1:0]    nv,
  input  logic [COREID_W-1:0] hart_id,
  input  logic                ready,
  output logic                valid,
  output logic [OVF_W-1:0]    vector,
  output logic [COREID_W-1:0] coreid,
  output logic [CNT_W-1:0]    coalesce_cnt
);
  logic [OVF_W-1:0] pend, merged;
  logic             fire;
  assign merged = pend | nv;
  assign fire   = ready && |merged;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend         <= '0;
      valid        <= 1'b0;
      vector       <= '0;
      coreid       <= '0;
      coalesce_cnt <= '0;
    end else begin
      valid  <= fire;
      coreid <= hart_id;
      pend   <= fire ? '0 : merged;
      if (fire) vector <= merged;
      // count only genuine merges into an already-pending vector, saturating
      if (!ready && |nv && |pend && ~&coalesce_cnt) coalesce_cnt <= coalesce_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mhpm_overflow_collector.sv
// mhpm_overflow_collector: sticky OF bits, LCOFI pulse and difftest overflow event feed
module mhpm_overflow_collector
  import mhpm_ovf_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [COREID_W-1:0] io_hartId,
  input  logic [NUM_HPM-1:0]  io_ovf_pulse,
  input  logic                io_of_wen,
  input  logic [4:0]          io_of_widx,
  input  logic                io_of_wdata,
  output logic [NUM_HPM-1:0]  io_of_bits,
  output logic                io_lcofi_set,
  input  logic                io_diff_ready,
  output logic                io_diff_enable,
  output logic                io_diff_valid,
  output logic [OVF_W-1:0]    io_diff_mhpmeventOverflow,
  output logic [COREID_W-1:0] io_diff_coreid,
  output logic [CNT_W-1:0]    io_coalesce_cnt
);
  logic [NUM_HPM-1:0] of, of_next, new_set;
  logic [OVF_W-1:0]   nv;
  always_comb begin
    new_set = io_ovf_pulse & ~of;
    of_next = of;
    // a hardware overflow wins over a same-cycle CSR write
    for (int i = 0; i < NUM_HPM; i++)
      of_next[i] = io_ovf_pulse[i] ? 1'b1 :
                   (io_of_wen && io_of_widx == 5'(CNT_BASE + i)) ? io_of_wdata : of[i];
  end
  assign nv = hpm_to_vec(new_set);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      of           <= '0;
      io_lcofi_set <= 1'b0;
    end else begin
      of           <= of_next;
      io_lcofi_set <= |new_set;
    end
  end
  assign io_of_bits     = of;
  assign io_diff_enable = io_diff_valid;
  mhpm_ovf_coalescer u_coalescer (
    .clock        (clock),
    .reset        (reset),
    .nv           (nv),
    .hart_id      (io_hartId),
    .ready        (io_diff_ready),
    .valid        (io_diff_valid),
    .vector       (io_diff_mhpmeventOverflow),
    .coreid       (io_diff_coreid),
    .coalesce_cnt (io_coalesce_cnt)
  );
endmodule
